// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg: shared widths and writeback entry type for the ALU result path
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package core_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [REG_AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [XLEN-1:0]   data;
        logic [REG_AW-1:0] rd;
        logic              we;
    } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/wb_fwd_match.sv
// ---------------------------------------------------------------------------
// wb_fwd_match: per-entry forwarding comparators plus youngest-match select
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module wb_fwd_match
    import core_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  wb_entry_t [DEPTH-1:0] entries,
    input  logic [DEPTH-1:0]      valid,
    input  logic [PW-1:0]         head,
    input  logic [REG_AW-1:0]     addr,
    output logic                  hit,
    output logic [XLEN-1:0]       data
);

    logic [DEPTH-1:0] w_match;
    logic [PW-1:0]    w_idx;

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
            assign w_match[i] = valid[i] && entries[i].we &&
                                (entries[i].rd != REG_ZERO) &&
                                (entries[i].rd == addr);
        end
    endgenerate

    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        hit   = 1'b0;
        data  = '0;
        w_idx = head;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = head + PW'(k);
            if (w_match[w_idx]) begin
                hit  = 1'b1;
                data = entries[w_idx].data;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_wb_buffer.sv
// ---------------------------------------------------------------------------
// alu_wb_buffer: two-entry ALU result FIFO feeding writeback, with bypass
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_wb_buffer
    import core_pkg::*;
#(
    parameter int XLEN   = core_pkg::XLEN,
    parameter int REG_AW = core_pkg::REG_AW,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_result,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_we,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [XLEN-1:0]   wb_data,
    output logic [REG_AW-1:0] wb_rd,
    output logic              wb_we,
    input  logic [REG_AW-1:0] fwd_addr,
    output logic              fwd_hit,
    output logic [XLEN-1:0]   fwd_data,
    output logic [1:0]        count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wb_entry_t [DEPTH-1:0] r_mem;
    logic [DEPTH-1:0]      r_valid;
    logic [PW-1:0]         r_head;
    logic [PW-1:0]         r_tail;
    logic [1:0]            r_count;

    logic      w_push;
    logic      w_pop;
    wb_entry_t w_head_entry;

    // in_ready depends only on registered occupancy, never on wb_ready.
    assign in_ready = (r_count != 2'(DEPTH));
    assign wb_valid = (r_count != 2'd0);
    assign w_push   = in_valid && in_ready;
    assign w_pop    = wb_valid && wb_ready;
    assign count    = r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else if (flush) begin
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else begin
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PW'(1);
            end
            if (w_push) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + PW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset: it is only observed through valid bits.
    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_mem[r_tail] <= '{data: in_result, rd: in_rd, we: in_we};
        end
    end

    assign w_head_entry = r_mem[r_head];
    assign wb_data      = wb_valid ? w_head_entry.data : '0;
    assign wb_rd        = wb_valid ? w_head_entry.rd   : '0;
    assign wb_we        = wb_valid && w_head_entry.we && (w_head_entry.rd != REG_ZERO);

    wb_fwd_match #(
        .DEPTH (DEPTH)
    ) u_fwd (
        .entries (r_mem),
        .valid   (r_valid),
        .head    (r_head),
        .addr    (fwd_addr),
        .hit     (fwd_hit),
        .data    (fwd_data)
    );

endmodule

`default_nettype wire

// File: tb/tb_alu_wb_buffer.sv
// ---------------------------------------------------------------------------
// tb_alu_wb_buffer: vector table, corner sequences and queue-model random test
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_alu_wb_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_we = 1'b0;
    logic        wb_ready = 1'b0;
    logic [31:0] in_result = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  fwd_addr = '0;
    logic        in_ready, wb_valid, wb_we, fwd_hit;
    logic [31:0] wb_data, fwd_data;
    logic [4:0]  wb_rd;
    logic [1:0]  count;

    alu_wb_buffer dut (
        .clk (clk), .rst (rst), .flush (flush),
        .in_valid (in_valid), .in_ready (in_ready), .in_result (in_result),
        .in_rd (in_rd), .in_we (in_we),
        .wb_valid (wb_valid), .wb_ready (wb_ready), .wb_data (wb_data),
        .wb_rd (wb_rd), .wb_we (wb_we),
        .fwd_addr (fwd_addr), .fwd_hit (fwd_hit), .fwd_data (fwd_data),
        .count (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
    } ent_t;

    typedef struct {
        logic        fl, iv, we, wr;
        logic [31:0] d;
        logic [4:0]  rd, fa;
        logic [1:0]  cnt;
        logic        rdy, wv, wwe, hit;
        logic [31:0] wd, fd;
        logic [4:0]  wrd;
    } vec_t;

    ent_t q[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    function automatic vec_t mk(input int fl, iv, d, rd, we, wr, fa,
                                input int cnt, rdy, wv, wd, wrd, wwe, hit, fd);
        vec_t v;
        v.fl = 1'(fl);   v.iv = 1'(iv);   v.d = 32'(d);   v.rd = 5'(rd);
        v.we = 1'(we);   v.wr = 1'(wr);   v.fa = 5'(fa);
        v.cnt = 2'(cnt); v.rdy = 1'(rdy); v.wv = 1'(wv);  v.wd = 32'(wd);
        v.wrd = 5'(wrd); v.wwe = 1'(wwe); v.hit = 1'(hit); v.fd = 32'(fd);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic fl, iv, input logic [31:0] d, input logic [4:0] rd,
                         input logic we, wr, input logic [4:0] fa);
        @(negedge clk);
        flush = fl; in_valid = iv; in_result = d; in_rd = rd; in_we = we;
        wb_ready = wr; fwd_addr = fa;
        #1;
    endtask

    // Expected outputs straight from the queue contents: head is q[0], youngest is the back.
    task automatic check_model(input string tag);
        logic        e_hit = 1'b0;
        logic [31:0] e_fd = '0;
        int          sz = q.size();
        for (int i = sz - 1; i >= 0; i--) begin
            if (!e_hit && q[i].we && q[i].rd != 5'd0 && q[i].rd == fwd_addr) begin
                e_hit = 1'b1;
                e_fd  = q[i].data;
            end
        end
        chk({tag, ".count"},    32'(count),    32'(sz));
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(sz < 2));
        chk({tag, ".wb_valid"}, 32'(wb_valid), 32'(sz > 0));
        chk({tag, ".wb_data"},  wb_data,       (sz > 0) ? q[0].data : 32'd0);
        chk({tag, ".wb_rd"},    32'(wb_rd),    (sz > 0) ? 32'(q[0].rd) : 32'd0);
        chk({tag, ".wb_we"},    32'(wb_we),    32'(sz > 0 && q[0].we && q[0].rd != 5'd0));
        chk({tag, ".fwd_hit"},  32'(fwd_hit),  32'(e_hit));
        chk({tag, ".fwd_data"}, fwd_data,      e_fd);
    endtask

    task automatic advance();
        int   sz = q.size();
        logic p  = in_valid && (sz < 2);
        logic pp = (sz > 0) && wb_ready;
        ent_t e;
        e.data = in_result; e.rd = in_rd; e.we = in_we;
        if (flush) begin
            q.delete();
        end else begin
            if (pp) void'(q.pop_front());
            if (p)  q.push_back(e);
        end
        @(posedge clk);
    endtask

    task automatic step(input string tag, input logic fl, iv, input logic [31:0] d,
                        input logic [4:0] rd, input logic we, wr, input logic [4:0] fa);
        drive(fl, iv, d, rd, we, wr, fa);
        check_model(tag);
        advance();
    endtask

    localparam int NV = 15;
    vec_t tbl[NV];

    initial begin
        // fl iv data rd we wr fa | cnt rdy wv wd rd we hit fd
        tbl[0]  = mk(0,1'b0,0,0,0,0,0,          0,1,0,0,0,0,0,0);
        tbl[1]  = mk(0,1,32'h8000_0001,5,1,1,5, 0,1,0,0,0,0,0,0);
        tbl[2]  = mk(0,0,0,0,0,1,5,             1,1,1,32'h8000_0001,5,1,1,32'h8000_0001);
        tbl[3]  = mk(0,0,0,0,0,0,5,             0,1,0,0,0,0,0,0);
        tbl[4]  = mk(0,1,32'h11,3,1,0,3,        0,1,0,0,0,0,0,0);
        tbl[5]  = mk(0,1,32'h22,3,1,0,3,        1,1,1,32'h11,3,1,1,32'h11);
        tbl[6]  = mk(0,0,0,0,0,0,3,             2,0,1,32'h11,3,1,1,32'h22);
        tbl[7]  = mk(0,0,0,0,0,1,3,             2,0,1,32'h11,3,1,1,32'h22);
        tbl[8]  = mk(0,0,0,0,0,1,3,             1,1,1,32'h22,3,1,1,32'h22);
        tbl[9]  = mk(0,1,32'hDEAD_BEEF,0,1,0,0, 0,1,0,0,0,0,0,0);
        tbl[10] = mk(0,0,0,0,0,0,0,             1,1,1,32'hDEAD_BEEF,0,0,0,0);
        tbl[11] = mk(0,1,32'h33,7,0,1,0,        1,1,1,32'hDEAD_BEEF,0,0,0,0);
        tbl[12] = mk(0,0,0,0,0,0,7,             1,1,1,32'h33,7,0,0,0);
        tbl[13] = mk(0,0,0,0,0,1,7,             1,1,1,32'h33,7,0,0,0);
        tbl[14] = mk(0,0,0,0,0,0,0,             0,1,0,0,0,0,0,0);

        #1 rst = 1'b1;
        #2;
        chk("reset.count",    32'(count),    32'd0);
        chk("reset.in_ready", 32'(in_ready), 32'd1);
        chk("reset.wb_valid", 32'(wb_valid), 32'd0);
        chk("reset.wb_we",    32'(wb_we),    32'd0);
        chk("reset.wb_data",  wb_data,       32'd0);
        chk("reset.fwd_hit",  32'(fwd_hit),  32'd0);
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].fl, tbl[i].iv, tbl[i].d, tbl[i].rd, tbl[i].we, tbl[i].wr, tbl[i].fa);
            chk($sformatf("v%0d.count", i),    32'(count),    32'(tbl[i].cnt));
            chk($sformatf("v%0d.in_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
            chk($sformatf("v%0d.wb_valid", i), 32'(wb_valid), 32'(tbl[i].wv));
            chk($sformatf("v%0d.wb_data", i),  wb_data,       tbl[i].wd);
            chk($sformatf("v%0d.wb_rd", i),    32'(wb_rd),    32'(tbl[i].wrd));
            chk($sformatf("v%0d.wb_we", i),    32'(wb_we),    32'(tbl[i].wwe));
            chk($sformatf("v%0d.fwd_hit", i),  32'(fwd_hit),  32'(tbl[i].hit));
            chk($sformatf("v%0d.fwd_data", i), fwd_data,      tbl[i].fd);
            advance();
        end

        // Streaming push+pop at count=1 with pointer wraparound.
        step("stream.fill", 0, 1, 32'hC000_0000, 5'd1, 1, 0, 5'd1);
        for (int i = 0; i < 6; i++) begin
            step($sformatf("stream%0d", i), 0, 1,
                 (i % 2 == 1) ? (32'h5A5A_0000 | 32'(i)) : (32'hA5A5_0000 | 32'(i)),
                 5'(i + 2), 1, 1, 5'(i + 1));
        end
        step("stream.drain0", 0, 0, 32'd0, 5'd0, 0, 1, 5'd7);
        step("stream.drain1", 0, 0, 32'd0, 5'd0, 0, 1, 5'd7);

        // Flush at count=2 with a same-cycle push attempt and pop request.
        step("fl2.a",   0, 1, 32'hF1, 5'd4, 1, 0, 5'd4);
        step("fl2.b",   0, 1, 32'hF2, 5'd4, 1, 0, 5'd4);
        step("fl2.fl",  1, 1, 32'hF3, 5'd4, 1, 1, 5'd4);
        step("fl2.aft", 0, 0, 32'd0,  5'd4, 0, 1, 5'd4);
        // Flush at count=1 while a push handshake completes: the push is dropped.
        step("fl1.a",   0, 1, 32'hE1, 5'd6, 1, 0, 5'd6);
        step("fl1.fl",  1, 1, 32'hE2, 5'd6, 1, 1, 5'd6);
        step("fl1.aft", 0, 0, 32'd0,  5'd6, 0, 1, 5'd6);

        // Asynchronous reset while full: outputs clear before any clock edge.
        step("ar.a", 0, 1, 32'hB1, 5'd9, 1, 0, 5'd9);
        step("ar.b", 0, 1, 32'hB2, 5'd9, 1, 0, 5'd9);
        @(negedge clk);
        in_valid = 1'b0; wb_ready = 1'b0;
        #1;
        chk("ar.pre.count", 32'(count), 32'd2);
        #1 rst = 1'b1;
        #1;
        chk("ar.count",    32'(count),    32'd0);
        chk("ar.wb_valid", 32'(wb_valid), 32'd0);
        chk("ar.wb_data",  wb_data,       32'd0);
        chk("ar.in_ready", 32'(in_ready), 32'd1);
        chk("ar.fwd_hit",  32'(fwd_hit),  32'd0);
        q.delete();
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 400; i++) begin
            step($sformatf("rnd%0d", i),
                 1'(($urandom % 16) == 0), 1'(($urandom % 4) != 0), $urandom,
                 5'($urandom % 4), 1'($urandom % 2), 1'($urandom % 2), 5'($urandom % 4));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_wb_buffer.md
Name: alu_wb_buffer

Overview:
- Two-entry result buffer directly downstream of the ALU/shift unit (ROR, shifts, arithmetic); consumes 32-bit results and hands them to register-file writeback.
- Valid/ready handshake on both sides, so a stalled writeback port never loses a result.
- Combinational forwarding lookup lets the operand-select stage bypass results that are still pending.

Parameters:
- XLEN, 32, result data width.
- REG_AW, 5, register address width.
- DEPTH, 2, entry count; fixed at 2 (power of two required).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous discard of all pending entries.
- in_valid  in  1  ALU result valid.
- in_ready  out  1  buffer can accept a result.
- in_result  in  XLEN  ALU/shift result (e.g. out_ror).
- in_rd  in  REG_AW  destination register.
- in_we  in  1  instruction writes rd.
- wb_valid  out  1  head entry valid.
- wb_ready  in  1  register file accepts head.
- wb_data  out  XLEN  head result.
- wb_rd  out  REG_AW  head destination.
- wb_we  out  1  head write enable, forced 0 when wb_rd==0.
- fwd_addr  in  REG_AW  source register queried by operand select.
- fwd_hit  out  1  pending entry matches fwd_addr.
- fwd_data  out  XLEN  data of youngest matching entry.
- count  out  2  occupancy, 0..2.

Behaviour:
- Reset is asynchronous, active-high:
  - count=0, pointers=0, all entry valid bits 0.
  - wb_valid=0, wb_data=0, wb_rd=0, wb_we=0, fwd_hit=0, in_ready=1.
- Push occurs when in_valid && in_ready. Pop occurs when wb_valid && wb_ready.
- in_ready = (count != 2). It is derived from registered occupancy only, with no combinational path from wb_ready.
- Latency: a pushed entry appears on wb_* in the next cycle (minimum 1 cycle).
- Ordering is strict FIFO. Storage is a circular buffer with 1-bit head/tail pointers that wrap 1->0.
- Simultaneous push and pop with count=1: count stays 1, head advances, tail advances. Data is not lost or duplicated.
- Simultaneous push and pop with count=0: no pop is possible because wb_valid=0. Push only.
- count=2 and pop: count becomes 1; in_ready rises the next cycle.
- wb_valid = (count != 0). wb_data, wb_rd and wb_we are muxed from the head entry. wb_data/wb_rd/wb_we read 0 when count=0.
- x0 rule: in_rd==0 entries are stored and retired normally, but wb_we=0 and they never forward.
- in_we=0 entries are retired (consume a slot) but never write or forward.
- Flush:
  - Next edge: count=0, head=tail=0, entries invalidated.
  - Flush has priority over a same-cycle push and pop; both are ignored.
  - A push handshake that completes in the flush cycle is dropped; the upstream side treats it as squashed.
- Forwarding (combinational):
  - fwd_hit=1 iff some valid entry has we=1, rd!=0 and rd==fwd_addr.
  - When both entries match, fwd_data comes from the younger (tail-1) entry.
  - When fwd_hit=0, fwd_data=0.
  - The head entry forwards even in the cycle it is being popped.
- Asserting rst mid-transfer discards all entries immediately, without waiting for a clock edge.

Decomposition:
- Shared package (core_pkg):
  - XLEN, REG_AW.
  - wb_entry_t struct {data, rd, we}.
  - Constant REG_ZERO=0.
- One natural sub-module, wb_fwd_match: a per-entry comparator returning hit, plus a youngest-select mux. It is instantiated once over the DEPTH entries.
- Everything else lives inline.

Test Plan:
- Reset then idle -> count=0, in_ready=1, wb_valid=0, wb_we=0, fwd_hit=0.
- Push {0x8000_0001, rd=5, we=1} with wb_ready=1 -> next cycle wb_valid=1, wb_data=0x8000_0001, wb_rd=5, wb_we=1; popped the same cycle; count returns to 0.
- wb_ready=0, push A=0x11 rd=3 then B=0x22 rd=3 -> count=2, in_ready=0, fwd_addr=3 gives fwd_hit=1, fwd_data=0x22. Then wb_ready=1 -> A retires first, then B.
- Push {0xDEAD_BEEF, rd=0, we=1} -> wb_valid=1, wb_we=0; fwd_addr=0 gives fwd_hit=0.
- count=1, then same-cycle push C and pop, held for 6 cycles with alternating data -> count stays 1, outputs appear in push order, and pointers wrap without loss.
- count=2 with flush=1 and in_valid=1 in the same cycle -> next cycle count=0 and wb_valid=0; the pushed data never appears. Async rst pulse mid-stream -> outputs go to 0 before the next clk edge.
